// File: rtl/alu_arbiter_if.sv
// Bundled request, response and shared-ALU signals for alu_arbiter.
// The slave modport is the arbiter, master is the requester side, alu is the ALU side.
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [2:0]  req0_op;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [2:0]  req1_op;
    logic        rsp0_valid;
    logic        rsp0_ready;
    logic [31:0] rsp0_ans;
    logic        rsp0_zero;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [31:0] rsp1_ans;
    logic        rsp1_zero;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_ans;
    logic        alu_zero;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_ans, rsp0_zero,
        output rsp1_valid, rsp1_ans, rsp1_zero,
        input  rsp0_ready, rsp1_ready,
        output alu_a, alu_b, alu_op,
        input  alu_ans, alu_zero
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_ans, rsp0_zero,
        input  rsp1_valid, rsp1_ans, rsp1_zero,
        output rsp0_ready, rsp1_ready
    );

    modport alu (
        input  alu_a, alu_b, alu_op,
        output alu_ans, alu_zero
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU (IDLE/EXEC/RESP).
// Define ALU_ARB_RR_EN for round-robin tie-break; otherwise requester 0 has fixed priority.
module alu_arbiter (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [2:0]  op_q;
    logic        owner;
    logic [31:0] ans_q;
    logic        zero_q;
    logic        any_valid;
    logic        winner;
    logic        take;

    assign any_valid = bus.req0_valid | bus.req1_valid;
    assign take      = (state == IDLE) && any_valid;

`ifdef ALU_ARB_RR_EN
    logic last;

    // On a tie the requester that was not granted most recently wins
    always_comb begin
        winner = (bus.req0_valid && bus.req1_valid) ? ~last : ~bus.req0_valid;
    end
`else
    always_comb begin
        winner = ~bus.req0_valid;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operands are captured only in the handshake cycle; the result only in EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            owner  <= 1'b0;
            ans_q  <= '0;
            zero_q <= 1'b0;
`ifdef ALU_ARB_RR_EN
            last   <= 1'b1;
`endif
        end else begin
            if (take) begin
                a_q   <= winner ? bus.req1_a  : bus.req0_a;
                b_q   <= winner ? bus.req1_b  : bus.req0_b;
                op_q  <= winner ? bus.req1_op : bus.req0_op;
                owner <= winner;
`ifdef ALU_ARB_RR_EN
                last  <= winner;
`endif
            end
            if (state == EXEC) begin
                ans_q  <= bus.alu_ans;
                zero_q <= bus.alu_zero;
            end
        end
    end

    // READY is gated by rst_n so it reads 0 for the whole reset window
    always_comb begin
        state_nxt      = state;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp0_valid = 1'b0;
        bus.rsp0_ans   = '0;
        bus.rsp0_zero  = 1'b0;
        bus.rsp1_valid = 1'b0;
        bus.rsp1_ans   = '0;
        bus.rsp1_zero  = 1'b0;
        bus.alu_a      = '0;
        bus.alu_b      = '0;
        bus.alu_op     = 3'b111;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    bus.req0_ready = rst_n & ~winner;
                    bus.req1_ready = rst_n & winner;
                    state_nxt      = EXEC;
                end
            end
            EXEC: begin
                bus.alu_a  = a_q;
                bus.alu_b  = b_q;
                bus.alu_op = op_q;
                state_nxt  = RESP;
            end
            RESP: begin
                if (owner) begin
                    bus.rsp1_valid = 1'b1;
                    bus.rsp1_ans   = ans_q;
                    bus.rsp1_zero  = zero_q;
                    if (bus.rsp1_ready) state_nxt = IDLE;
                end else begin
                    bus.rsp0_valid = 1'b1;
                    bus.rsp0_ans   = ans_q;
                    bus.rsp0_zero  = zero_q;
                    if (bus.rsp0_ready) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
